// File: rtl/timer_irq_ctrl.sv
// APB interrupt aggregator: captures rising edges of level sources into PENDING,
// tracks OVERRUN, masks through ENABLE and offers a lowest-index CLAIM register.
module timer_irq_ctrl #(
    parameter int IRQ_NUM = 4
) (
    input  logic               pclk,
    input  logic               prst,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [11:0]        paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    input  logic [IRQ_NUM-1:0] irq_src_i,
    output logic               irq_o
);

    localparam logic [2:0] IDX_ENABLE  = 3'd0;
    localparam logic [2:0] IDX_PENDING = 3'd1;
    localparam logic [2:0] IDX_RAW     = 3'd2;
    localparam logic [2:0] IDX_CLAIM   = 3'd3;
    localparam logic [2:0] IDX_OVERRUN = 3'd4;

    logic [IRQ_NUM-1:0] src_q;
    logic [IRQ_NUM-1:0] enable_q;
    logic [IRQ_NUM-1:0] pending_q;
    logic [IRQ_NUM-1:0] overrun_q;

    logic               access;
    logic               wr_acc;
    logic               rd_acc;
    logic [2:0]         idx;
    logic               bad_idx;
    logic [IRQ_NUM-1:0] irq_edge;
    logic [IRQ_NUM-1:0] active;
    logic [IRQ_NUM-1:0] claim_mask;
    logic [IRQ_NUM-1:0] pend_clr;
    logic [IRQ_NUM-1:0] ovr_clr;
    logic [IRQ_NUM-1:0] pend_nxt;
    logic [IRQ_NUM-1:0] ovr_nxt;
    logic [IRQ_NUM-1:0] enable_nxt;
    logic               unused_bits;

    // Claim value is 1-based so that 0 can mean "nothing to service".
    function automatic logic [5:0] claim_id(input logic [IRQ_NUM-1:0] act);
        logic [5:0] id;
        id = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (act[i]) id = 6'(i + 1);
        end
        return id;
    endfunction

    assign unused_bits = ^{paddr[11:5], paddr[1:0], pwdata};
    assign pready      = 1'b1;

    always_comb begin
        access     = psel & penable;
        wr_acc     = access & pwrite;
        rd_acc     = access & ~pwrite;
        idx        = paddr[4:2];
        bad_idx    = (idx > IDX_OVERRUN);
        irq_edge   = irq_src_i & ~src_q;
        active     = pending_q & enable_q;
        // Isolate the lowest set bit of the active vector: the line a claim retires.
        claim_mask = active & (~active + IRQ_NUM'(1));

        pend_clr   = '0;
        ovr_clr    = '0;
        enable_nxt = enable_q;
        if (wr_acc && idx == IDX_PENDING) pend_clr = pwdata[IRQ_NUM-1:0];
        if (rd_acc && idx == IDX_CLAIM)   pend_clr = claim_mask;
        if (wr_acc && idx == IDX_OVERRUN) ovr_clr  = pwdata[IRQ_NUM-1:0];
        if (wr_acc && idx == IDX_ENABLE)  enable_nxt = pwdata[IRQ_NUM-1:0];

        // Sets are OR'd in after clears so a coincident edge always wins.
        pend_nxt = (pending_q & ~pend_clr) | irq_edge;
        ovr_nxt  = (overrun_q & ~ovr_clr) | (irq_edge & pending_q & ~pend_clr);
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            src_q     <= '0;
            enable_q  <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            src_q     <= irq_src_i;
            enable_q  <= enable_nxt;
            pending_q <= pend_nxt;
            overrun_q <= ovr_nxt;
        end
    end

    always_comb begin
        prdata = '0;
        if (rd_acc && !prst) begin
            case (idx)
                IDX_ENABLE:  prdata = 32'(enable_q);
                IDX_PENDING: prdata = 32'(pending_q);
                IDX_RAW:     prdata = 32'(irq_src_i);
                IDX_CLAIM:   prdata = 32'(claim_id(active));
                IDX_OVERRUN: prdata = 32'(overrun_q);
                default:     prdata = '0;
            endcase
        end
    end

    assign pslverr = access & bad_idx & ~prst;
    assign irq_o   = (|active) & ~prst;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with hand-computed expectations (IRQ_NUM = 4).
module tb_timer_irq_ctrl;

    logic        pclk = 1'b0;
    logic        prst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [3:0]  irq_src_i;
    logic        irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [11:0] A_EN  = 12'h000;
    localparam logic [11:0] A_PND = 12'h004;
    localparam logic [11:0] A_RAW = 12'h008;
    localparam logic [11:0] A_CLM = 12'h00C;
    localparam logic [11:0] A_OVR = 12'h010;

    timer_irq_ctrl #(.IRQ_NUM(4)) dut (
        .pclk      (pclk),
        .prst      (prst),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr),
        .irq_src_i (irq_src_i),
        .irq_o     (irq_o)
    );

    always #5 pclk = ~pclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Setup phase then access phase; src_or is OR'd onto the sources only during the access cycle.
    task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                       input logic [3:0] src_or, output logic [31:0] rd, output logic err);
        logic [3:0] prev;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
        @(negedge pclk);
        prev = irq_src_i;
        penable = 1'b1;
        irq_src_i = prev | src_or;
        #1;
        rd  = prdata;
        err = pslverr;
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pwdata = '0;
        irq_src_i = prev;
    endtask

    task automatic rd32(input logic [11:0] addr, output logic [31:0] d);
        logic e;
        apb(1'b0, addr, 32'h0, 4'h0, d, e);
    endtask

    task automatic wr32(input logic [11:0] addr, input logic [31:0] wd);
        logic [31:0] d;
        logic e;
        apb(1'b1, addr, wd, 4'h0, d, e);
    endtask

    task automatic pulse(input logic [3:0] m);
        @(negedge pclk);
        irq_src_i = m;
        @(negedge pclk);
        irq_src_i = 4'h0;
    endtask

    initial begin
        logic [31:0] d;
        logic        e;

        prst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        paddr = 12'h014; pwdata = '0; irq_src_i = 4'h0;
        repeat (2) @(negedge pclk);
        #1;
        chk("rst_prdata", prdata, 32'h0);
        chk("rst_pslverr", {31'h0, pslverr}, 32'h0);
        chk("rst_irq", {31'h0, irq_o}, 32'h0);
        chk("pready", {31'h0, pready}, 32'h1);
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        prst = 1'b0;
        rd32(A_EN, d);  chk("rst_enable", d, 32'h0);
        rd32(A_PND, d); chk("rst_pending", d, 32'h0);
        rd32(A_OVR, d); chk("rst_overrun", d, 32'h0);

        // Single pulse on line 2, then claim
        wr32(A_EN, 32'hF);
        pulse(4'b0100);
        #1 chk("p2_irq", {31'h0, irq_o}, 32'h1);
        rd32(A_PND, d); chk("p2_pending", d, 32'h4);
        rd32(A_CLM, d); chk("p2_claim", d, 32'h3);
        rd32(A_PND, d); chk("p2_pend_after", d, 32'h0);
        #1 chk("p2_irq_after", {31'h0, irq_o}, 32'h0);

        // Two lines claimed in index order
        pulse(4'b1010);
        rd32(A_CLM, d); chk("c13_first", d, 32'h2);
        rd32(A_CLM, d); chk("c13_second", d, 32'h4);
        rd32(A_CLM, d); chk("c13_empty", d, 32'h0);

        // Overrun on line 0
        pulse(4'b0001);
        pulse(4'b0001);
        rd32(A_OVR, d); chk("ovr_set", d, 32'h1);
        wr32(A_OVR, 32'h1);
        rd32(A_OVR, d); chk("ovr_w1c", d, 32'h0);
        rd32(A_PND, d); chk("ovr_pend", d, 32'h1);
        wr32(A_PND, 32'h1);
        rd32(A_PND, d); chk("pend_w1c", d, 32'h0);

        // Edge on line 1 coinciding with W1C of PENDING[1]
        pulse(4'b0010);
        apb(1'b1, A_PND, 32'h2, 4'b0010, d, e);
        rd32(A_PND, d); chk("setclr_pend", d, 32'h2);
        rd32(A_OVR, d); chk("setclr_ovr", d, 32'h0);
        wr32(A_PND, 32'h2);

        // Masked line: pending kept, irq and claim masked
        wr32(A_EN, 32'h0);
        pulse(4'b0001);
        #1 chk("mask_irq", {31'h0, irq_o}, 32'h0);
        rd32(A_PND, d); chk("mask_pend", d, 32'h1);
        rd32(A_CLM, d); chk("mask_claim", d, 32'h0);
        rd32(A_PND, d); chk("mask_pend_kept", d, 32'h1);
        wr32(A_EN, 32'h1);
        #1 chk("unmask_irq", {31'h0, irq_o}, 32'h1);

        // RAW mirrors sources; edges seen during that read also land in PENDING
        apb(1'b0, A_RAW, 32'h0, 4'hA, d, e);
        chk("raw", d, 32'hA);
        rd32(A_PND, d); chk("raw_pend", d, 32'hB);
        wr32(A_EN, 32'hFFFF_FFFF);
        rd32(A_EN, d); chk("en_upper", d, 32'hF);
        wr32(A_CLM, 32'hF);
        wr32(A_RAW, 32'hF);
        rd32(A_PND, d); chk("claim_wr_ignored", d, 32'hB);

        // Unmapped index
        apb(1'b0, 12'h014, 32'h0, 4'h0, d, e);
        chk("bad_rd_data", d, 32'h0);
        chk("bad_rd_err", {31'h0, e}, 32'h1);
        apb(1'b1, 12'h01C, 32'h0, 4'h0, d, e);
        chk("bad_wr_err", {31'h0, e}, 32'h1);
        apb(1'b0, A_EN, 32'h0, 4'h0, d, e);
        chk("good_err", {31'h0, e}, 32'h0);
        chk("bad_wr_noeffect", d, 32'hF);

        // Reset with pending and overrun set
        pulse(4'b0100);
        pulse(4'b0100);
        @(negedge pclk);
        prst = 1'b1;
        #1 chk("rst_irq_gate", {31'h0, irq_o}, 32'h0);
        @(negedge pclk);
        prst = 1'b0;
        rd32(A_PND, d); chk("rst2_pending", d, 32'h0);
        rd32(A_OVR, d); chk("rst2_overrun", d, 32'h0);
        rd32(A_EN, d);  chk("rst2_enable", d, 32'h0);

        // Source high across reset release registers an edge once
        @(negedge pclk);
        prst = 1'b1; irq_src_i = 4'b0001;
        @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);
        rd32(A_PND, d); chk("post_rst_edge", d, 32'h1);
        wr32(A_PND, 32'h1);
        rd32(A_PND, d); chk("held_high_no_edge", d, 32'h0);
        irq_src_i = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
TIMER_IRQ_CTRL -- requirements
Module: timer_irq_ctrl

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 4, number of interrupt source lines (1..32); sized to take a timer bank's irq_o vector (2 lines per timer).
REQ-002 SHALL have port pclk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port prst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port psel, input, 1, APB select.
REQ-005 SHALL have port penable, input, 1, APB access phase.
REQ-006 SHALL have port pwrite, input, 1, 1 = write, 0 = read.
REQ-007 SHALL have port paddr, input, 12, byte address; only paddr[4:2] is decoded.
REQ-008 SHALL have port pwdata, input, 32, write data.
REQ-009 SHALL have port prdata, output, 32, read data.
REQ-010 SHALL have port pready, output, 1, tied 1.
REQ-011 SHALL have port pslverr, output, 1, error response.
REQ-012 SHALL have port irq_src_i, input, IRQ_NUM, level interrupt sources; single-cycle pulses are legal.
REQ-013 SHALL have port irq_o, output, 1, aggregated interrupt to the CPU.

Function
REQ-014 SHALL hold a registered copy src_q of irq_src_i and SHALL define edge = irq_src_i & ~src_q.
REQ-015 SHALL set PENDING[i] on the clock edge at which edge[i]=1, so a 1-cycle pulse is captured with 1-cycle latency.
REQ-016 SHALL set OVERRUN[i] when edge[i]=1 and PENDING[i] is already 1.
REQ-017 SHALL drive irq_o = |(PENDING & ENABLE) combinationally from registers; irq_o rises 1 cycle after the source edge.
REQ-018 SHALL define an access as psel & penable; the register map (word index paddr[4:2]) is: 0 ENABLE (RW), 1 PENDING (R, W1C), 2 RAW (R, = irq_src_i), 3 CLAIM (R), 4 OVERRUN (R, W1C).
REQ-019 SHALL drive pslverr=1 for an access to index 5..7; such writes have no effect and such reads return 0.
REQ-020 SHALL drive prdata with the addressed register during a read access and 0 at all other times.
REQ-021 SHALL return 0 in bits IRQ_NUM..31 on every read and ignore those bits on every write.
REQ-022 SHALL return on a CLAIM read the value 1 + (lowest index i with PENDING[i] & ENABLE[i]), or 0 if no such i exists.
REQ-023 SHALL clear the claimed PENDING bit on the clock edge ending the CLAIM read access; each access causes exactly one clear.
REQ-024 SHALL ignore writes to CLAIM and writes to RAW.
REQ-025 SHALL give a set priority over a clear: if edge[i] coincides with a W1C of PENDING[i] or a claim of line i, PENDING[i] ends at 1 and OVERRUN[i] is not set.
REQ-026 SHALL give a new edge priority over a W1C of OVERRUN[i] when both occur on the same edge (OVERRUN[i] ends at 1).
REQ-027 SHALL keep PENDING and OVERRUN unchanged when ENABLE[i]=0; only irq_o and CLAIM are masked.
REQ-028 SHALL not raise irq_o for a source held high continuously; a new 0->1 transition is required.

Reset
REQ-029 SHALL, while prst=1 at a clock edge, clear ENABLE, PENDING, OVERRUN and src_q to 0; irq_o=0, prdata=0 and pslverr=0 during reset.
REQ-030 SHALL, if a source is high when prst falls, register an edge on the first active edge after reset (src_q resets to 0).
REQ-031 SHALL let reset override any access or edge in the same cycle.

Verification
REQ-032 SHALL cover: ENABLE=0xF, 1-cycle pulse on irq_src_i[2] -> PENDING=0x4 next cycle, irq_o=1, CLAIM read=3, then PENDING=0 and irq_o=0.
REQ-033 SHALL cover: pulses on lines 1 and 3 with ENABLE=0xF -> CLAIM reads return 2, then 4, then 0.
REQ-034 SHALL cover: a second pulse on line 0 before it is cleared -> OVERRUN=0x1; W1C 0x1 to OVERRUN -> 0.
REQ-035 SHALL cover: an edge on line 1 in the same cycle as a W1C 0x2 to PENDING -> PENDING[1]=1 and OVERRUN[1]=0.
REQ-036 SHALL cover: ENABLE=0, pulse on line 0 -> PENDING=0x1, irq_o=0, CLAIM=0; writing ENABLE=0x1 -> irq_o=1.
REQ-037 SHALL cover: a read of paddr=0x14 -> pslverr=1, prdata=0; prst asserted with pending set -> all registers 0 next cycle.
